fifo_rd_ctrl: RTL and testbench
===============================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and storage depth at 8 entries.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 rd_en  input  1  read request, sampled at the clk rising edge.
REQ-006 wr_push  input  1  writer stored one entry at the clk rising edge.
REQ-007 mem_flat  input  256  outputs of the eight 32-bit enabled storage registers; entry k occupies bits [32k+31:32k].
REQ-008 d_out  output  32  registered read data.
REQ-009 rd_ack  output  1  the previous edge performed a successful read.
REQ-010 rd_err  output  1  the previous edge rejected a read because the FIFO was empty.
REQ-011 empty  output  1  data_count == 0.
REQ-012 full  output  1  data_count == 8.
REQ-013 data_count  output  4  number of stored entries, 0..8.
REQ-014 rd_ptr  output  3  index of the next entry to read.

Function
REQ-015 State machine states SHALL be INIT, NO_OP, READ and RD_ERROR; the state records the action of the most recent edge.
REQ-016 INIT SHALL last exactly one cycle after reset release and then go to NO_OP, or to READ/RD_ERROR per REQ-018 if rd_en is high on that edge.
REQ-017 Definitions: rd_ok = rd_en & ~empty; push_ok = wr_push & ~full; all are evaluated on pre-edge values.
REQ-018 From any state, each edge SHALL go to READ if rd_ok, to RD_ERROR if rd_en & empty, and to NO_OP otherwise.
REQ-019 rd_ack SHALL be 1 only in READ, and rd_err SHALL be 1 only in RD_ERROR; both are mutually exclusive and are registered state decodes.
REQ-020 On rd_ok, d_out SHALL load mem_flat entry rd_ptr, so data is valid in the cycle rd_ack is high (one-cycle latency from the rd_en edge).
REQ-021 d_out SHALL hold its value on every edge without rd_ok, including RD_ERROR.
REQ-022 rd_ptr SHALL increment modulo 8 on rd_ok (7 -> 0) and hold otherwise.
REQ-023 data_count SHALL update as data_count + push_ok - rd_ok on every edge.
REQ-024 Simultaneous rd_en and wr_push when empty: the read errors, the push is accepted, and data_count becomes 1.
REQ-025 Simultaneous rd_en and wr_push when 0 < count < 8: both are accepted and data_count is unchanged.
REQ-026 Simultaneous rd_en and wr_push when full: the read succeeds, the push is ignored, and data_count becomes 7.
REQ-027 wr_push while full without rd_en SHALL be ignored, with no state change other than returning to NO_OP.
REQ-028 Sustained rd_en on a nonempty FIFO SHALL read one entry per cycle with no bubble.
REQ-029 empty and full SHALL be combinational decodes of registered data_count.

Reset
REQ-030 While reset_n is 0, regardless of clk: state = INIT, d_out = 0, rd_ptr = 0, data_count = 0, rd_ack = 0, rd_err = 0, empty = 1, full = 0.
REQ-031 Reset asserted mid-operation SHALL abandon any read in progress immediately, with no partial update surviving.
REQ-032 Reset release SHALL be safe mid-cycle; the first state update occurs on the first rising edge with reset_n = 1.

Verification
REQ-033 Reset then idle 3 cycles -> all outputs at the REQ-030 values; the state passes INIT -> NO_OP.
REQ-034 Push 3 (entry k = 32'h1000_000k), then rd_en for 3 cycles -> d_out = 0x10000000, 0x10000001, 0x10000002 on consecutive cycles, rd_ack = 1 on each, data_count 3 -> 0, then empty = 1.
REQ-035 rd_en when empty with d_out = 0x10000002 -> rd_err = 1 for one cycle, d_out unchanged, rd_ptr and data_count unchanged.
REQ-036 Push 8 -> full = 1; a 9th push is ignored (count stays 8); rd_en and wr_push together -> rd_ack = 1, count = 7.
REQ-037 Push and read 10 entries total -> rd_ptr wraps 7 -> 0 -> 1, and entry 0 is re-read with current contents.
REQ-038 Assert reset_n = 0 between clk edges during a read burst -> outputs take the REQ-030 values immediately, without waiting for an edge.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side controller for an 8-entry x 32-bit FIFO whose storage registers
// live outside this block. It tracks occupancy (pushes reported by the writer,
// pops performed here), keeps the read pointer, registers the read data and
// reports the outcome of each clock edge through a small state machine.
//
// Ports
//   clk         rising-edge clock for all state
//   reset_n     asynchronous active-low reset
//   rd_en       read request
//   wr_push     writer stored one entry on this edge
//   mem_flat    the eight storage registers, entry k at [32k+31:32k]
//   d_out       registered read data, valid while rd_ack is high
//   rd_ack      previous edge performed a successful read
//   rd_err      previous edge rejected a read because the FIFO was empty
//   empty       data_count == 0
//   full        data_count == 8
//   data_count  stored entries, 0..8
//   rd_ptr      index of the next entry to read
// ----------------------------------------------------------------------------
module fifo_rd_ctrl (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         rd_en,
    input  logic         wr_push,
    input  logic [255:0] mem_flat,
    output logic [31:0]  d_out,
    output logic         rd_ack,
    output logic         rd_err,
    output logic         empty,
    output logic         full,
    output logic [3:0]   data_count,
    output logic [2:0]   rd_ptr
);

    // The state records what the most recent edge did.
    typedef enum logic [1:0] {
        StInit,
        StNoOp,
        StRead,
        StRdError
    } state_e;

    state_e      state_q;
    logic        rd_ok;
    logic        rd_fail;
    logic        push_ok;
    logic [3:0]  count_d;
    logic [31:0] rd_data;

    assign empty = (data_count == 4'd0);
    assign full  = (data_count == 4'd8);

    // All qualifiers use pre-edge occupancy.
    assign rd_ok   = rd_en & ~empty;
    assign rd_fail = rd_en & empty;
    assign push_ok = wr_push & ~full;

    assign rd_data = mem_flat[{rd_ptr, 5'd0} +: 32];

    // A push and a pop on the same edge cancel out.
    always_comb begin
        count_d = data_count;
        if (push_ok && !rd_ok) begin
            count_d = data_count + 4'd1;
        end else if (rd_ok && !push_ok) begin
            count_d = data_count - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StInit;
            d_out      <= 32'd0;
            rd_ptr     <= 3'd0;
            data_count <= 4'd0;
        end else begin
            data_count <= count_d;
            if (rd_ok) begin
                state_q <= StRead;
                d_out   <= rd_data;
                rd_ptr  <= rd_ptr + 3'd1;   // wraps 7 -> 0 naturally
            end else if (rd_fail) begin
                state_q <= StRdError;
            end else begin
                state_q <= StNoOp;
            end
        end
    end

    // Decodes of the registered state, so both are glitch-free and exclusive.
    assign rd_ack = (state_q == StRead);
    assign rd_err = (state_q == StRdError);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

    logic         clk;
    logic         reset_n;
    logic         rd_en;
    logic         wr_push;
    logic [255:0] mem_flat;
    logic [31:0]  d_out;
    logic         rd_ack;
    logic         rd_err;
    logic         empty;
    logic         full;
    logic [3:0]   data_count;
    logic [2:0]   rd_ptr;

    logic [31:0]  mem [8];
    int           tests;
    int           fails;
    int           wp;

    fifo_rd_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_en      (rd_en),
        .wr_push    (wr_push),
        .mem_flat   (mem_flat),
        .d_out      (d_out),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .empty      (empty),
        .full       (full),
        .data_count (data_count),
        .rd_ptr     (rd_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 8; k++) mem_flat[k*32 +: 32] = mem[k];
    end

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Writer model: store into the next slot and pulse wr_push.
    task automatic push_only(input logic [31:0] v);
        mem[wp] = v;
        wp = (wp + 1) % 8;
        wr_push = 1'b1;
        rd_en = 1'b0;
        step();
        wr_push = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rd_en = 1'b0;
        wr_push = 1'b0;
        for (int k = 0; k < 8; k++) mem[k] = 32'hdead_0000 + k;
        wp = 0;
        #2;
        tests++; if (d_out !== 32'd0) begin fails++; $display("FAIL rst_d_out got %h exp 0", d_out); end
        tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL rst_flags got e=%b f=%b exp e=1 f=0", empty, full); end
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;   // release mid-cycle
        repeat (3) step();
        tests++; if (d_out !== 32'd0) begin fails++; $display("FAIL idle_d_out got %h exp 0", d_out); end
        tests++; if (rd_ptr !== 3'd0) begin fails++; $display("FAIL idle_rd_ptr got %0d exp 0", rd_ptr); end
        tests++; if (data_count !== 4'd0) begin fails++; $display("FAIL idle_count got %0d exp 0", data_count); end
        tests++; if (rd_ack !== 1'b0 || rd_err !== 1'b0) begin fails++; $display("FAIL idle_ack_err got %b%b exp 00", rd_ack, rd_err); end
        tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL idle_flags got e=%b f=%b exp e=1 f=0", empty, full); end
    endtask

    task automatic test_read_burst();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h1000_0000;
        exp_d[1] = 32'h1000_0001;
        exp_d[2] = 32'h1000_0002;
        for (int i = 0; i < 3; i++) push_only(exp_d[i]);
        tests++; if (data_count !== 4'd3) begin fails++; $display("FAIL burst_fill got %0d exp 3", data_count); end
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (d_out !== exp_d[i] || rd_ack !== 1'b1) begin fails++; $display("FAIL burst_rd%0d got d=%h ack=%b exp d=%h ack=1", i, d_out, rd_ack, exp_d[i]); end
            tests++; if (data_count !== 4'(2 - i)) begin fails++; $display("FAIL burst_cnt%0d got %0d exp %0d", i, data_count, 2 - i); end
        end
        rd_en = 1'b0;
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL burst_empty got %b exp 1", empty); end
    endtask

    task automatic test_read_empty();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        tests++; if (rd_err !== 1'b1 || rd_ack !== 1'b0) begin fails++; $display("FAIL empty_err got err=%b ack=%b exp err=1 ack=0", rd_err, rd_ack); end
        tests++; if (d_out !== 32'h1000_0002) begin fails++; $display("FAIL empty_hold got %h exp 10000002", d_out); end
        tests++; if (rd_ptr !== 3'd3 || data_count !== 4'd0) begin fails++; $display("FAIL empty_ptr_cnt got p=%0d c=%0d exp p=3 c=0", rd_ptr, data_count); end
        step();
        tests++; if (rd_err !== 1'b0) begin fails++; $display("FAIL empty_err_clear got %b exp 0", rd_err); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) push_only(32'h2000_0000 + i);
        tests++; if (full !== 1'b1 || data_count !== 4'd8) begin fails++; $display("FAIL full_fill got f=%b c=%0d exp f=1 c=8", full, data_count); end
        // Ignored push: the writer does not overwrite its storage.
        wr_push = 1'b1;
        step();
        tests++; if (data_count !== 4'd8 || rd_ack !== 1'b0) begin fails++; $display("FAIL full_ninth got c=%0d ack=%b exp c=8 ack=0", data_count, rd_ack); end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        wr_push = 1'b0;
        tests++; if (rd_ack !== 1'b1 || data_count !== 4'd7) begin fails++; $display("FAIL full_rdwr got ack=%b c=%0d exp ack=1 c=7", rd_ack, data_count); end
        tests++; if (d_out !== 32'h2000_0000 || rd_ptr !== 3'd4) begin fails++; $display("FAIL full_rdwr_data got d=%h p=%0d exp d=20000000 p=4", d_out, rd_ptr); end
        rd_en = 1'b1;
        repeat (7) step();
        rd_en = 1'b0;
        tests++; if (d_out !== 32'h2000_0007 || data_count !== 4'd0 || rd_ptr !== 3'd3) begin fails++; $display("FAIL full_drain got d=%h c=%0d p=%0d exp d=20000007 c=0 p=3", d_out, data_count, rd_ptr); end
    endtask

    // rd_ptr starts at 3; ten reads visit 3..7,0,1,2,3,4 and entry 0 holds push #5.
    task automatic test_wrap();
        push_only(32'h3000_0000);
        for (int i = 1; i < 10; i++) begin
            mem[wp] = 32'h3000_0000 + i;
            wp = (wp + 1) % 8;
            wr_push = 1'b1;
            rd_en = 1'b1;
            step();
            tests++; if (d_out !== 32'h3000_0000 + i - 1 || rd_ptr !== 3'((4 + i - 1) % 8) || data_count !== 4'd1) begin
                fails++; $display("FAIL wrap_rd%0d got d=%h p=%0d c=%0d exp d=%h p=%0d c=1", i, d_out, rd_ptr, data_count, 32'h3000_0000 + i - 1, (4 + i - 1) % 8);
            end
        end
        wr_push = 1'b0;
        step();
        rd_en = 1'b0;
        tests++; if (d_out !== 32'h3000_0009 || rd_ptr !== 3'd5 || empty !== 1'b1) begin fails++; $display("FAIL wrap_last got d=%h p=%0d e=%b exp d=30000009 p=5 e=1", d_out, rd_ptr, empty); end
    endtask

    task automatic test_reset_mid();
        push_only(32'h4000_0000);
        push_only(32'h4000_0001);
        rd_en = 1'b1;
        step();
        #3 reset_n = 1'b0;
        #1;
        tests++; if (d_out !== 32'd0 || rd_ack !== 1'b0 || rd_err !== 1'b0) begin fails++; $display("FAIL midrst_out got d=%h ack=%b err=%b exp 0 0 0", d_out, rd_ack, rd_err); end
        tests++; if (rd_ptr !== 3'd0 || data_count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL midrst_cnt got p=%0d c=%0d e=%b f=%b exp 0 0 1 0", rd_ptr, data_count, empty, full); end
        rd_en = 1'b0;
        #2 reset_n = 1'b1;
        wp = 0;
        step();
        tests++; if (data_count !== 4'd0 || d_out !== 32'd0 || rd_ack !== 1'b0) begin fails++; $display("FAIL midrst_after got c=%0d d=%h ack=%b exp 0 0 0", data_count, d_out, rd_ack); end
        // Simultaneous read and push on empty: read errors, push lands.
        mem[0] = 32'h5000_0000;
        wp = 1;
        rd_en = 1'b1;
        wr_push = 1'b1;
        step();
        rd_en = 1'b0;
        wr_push = 1'b0;
        tests++; if (rd_err !== 1'b1 || data_count !== 4'd1 || rd_ptr !== 3'd0) begin fails++; $display("FAIL empty_rdwr got err=%b c=%0d p=%0d exp 1 1 0", rd_err, data_count, rd_ptr); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_read_burst();
        test_read_empty();
        test_full();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
